// File: rtl/opcol_pkg.sv
// Shared types and constants for the six-operand collector and its carry-save summing tree.
package opcol_pkg;

  localparam int unsigned OPW  = 8;
  localparam int unsigned NOPS = 6;
  localparam int unsigned SUMW = 11;

  typedef logic [OPW-1:0]  operand_t;
  typedef logic [SUMW-1:0] sum_t;

  // Bit-column form: [column i][operand k] = bit i of operand k.
  typedef logic [OPW-1:0][NOPS-1:0] col_matrix_t;

  typedef enum logic [1:0] {COLLECT, SUM, OUT} state_t;

  // 3:2 compressor over full-width vectors.
  function automatic sum_t csa_sum(input sum_t a, input sum_t b, input sum_t c);
    return a ^ b ^ c;
  endfunction

  // The shift cannot drop a set bit: the group total stays below 2**SUMW.
  function automatic sum_t csa_carry(input sum_t a, input sum_t b, input sum_t c);
    return ((a & b) | (a & c) | (b & c)) << 1;
  endfunction

endpackage

// File: rtl/operand_sum6.sv
// Purely combinational six-operand carry-save tree with a final carry-propagate adder.
module operand_sum6
  import opcol_pkg::*;
(
  input  col_matrix_t cols_i,
  output sum_t        sum_o
);

  sum_t ops [NOPS];
  sum_t s_abc, c_abc, s_def, c_def;
  sum_t s_mid, c_mid, s_fin, c_fin;

  // Rebuild zero-extended operand rows from the bit columns.
  always_comb begin
    for (int k = 0; k < NOPS; k++) begin
      ops[k] = '0;
      for (int i = 0; i < OPW; i++) begin
        ops[k][i] = cols_i[i][k];
      end
    end
  end

  assign s_abc = csa_sum(ops[0], ops[1], ops[2]);
  assign c_abc = csa_carry(ops[0], ops[1], ops[2]);
  assign s_def = csa_sum(ops[3], ops[4], ops[5]);
  assign c_def = csa_carry(ops[3], ops[4], ops[5]);

  assign s_mid = csa_sum(s_abc, c_abc, s_def);
  assign c_mid = csa_carry(s_abc, c_abc, s_def);

  assign s_fin = csa_sum(s_mid, c_mid, c_def);
  assign c_fin = csa_carry(s_mid, c_mid, c_def);

  assign sum_o = s_fin + c_fin;

endmodule

// File: rtl/operand_collector6.sv
// Collects six 8-bit operands, sums them through operand_sum6 and returns an 11-bit result.
// Define OPERAND_COLLECTOR_FLUSH_EN to add in_last, which closes a group early.
module operand_collector6
  import opcol_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] in_data,
`ifdef OPERAND_COLLECTOR_FLUSH_EN
  input  logic           in_last,
`endif
  output logic           out_valid,
  input  logic           out_ready,
  output logic [SUMW-1:0] out_sum,
  output logic [2:0]     out_count
);

  localparam logic [2:0] LastIdx = 3'(NOPS - 1);

  state_t                  state_q, state_d;
  logic [2:0]              idx_q, idx_d;
  operand_t [NOPS-1:0]     ops_q, ops_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  sum_t                    out_sum_q, out_sum_d;
  logic [2:0]              out_count_q, out_count_d;
`ifdef OPERAND_COLLECTOR_FLUSH_EN
  logic [2:0]              grp_cnt_q, grp_cnt_d;
`endif

  col_matrix_t cols;
  sum_t        tree_sum;
  logic        close_grp;

  always_comb begin
    cols = '0;
    for (int i = 0; i < OPW; i++) begin
      for (int k = 0; k < NOPS; k++) begin
        cols[i][k] = ops_q[k][i];
      end
    end
  end

  operand_sum6 u_sum6 (
    .cols_i (cols),
    .sum_o  (tree_sum)
  );

`ifdef OPERAND_COLLECTOR_FLUSH_EN
  assign close_grp = (idx_q == LastIdx) || in_last;
`else
  assign close_grp = (idx_q == LastIdx);
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ops_d       = ops_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
`ifdef OPERAND_COLLECTOR_FLUSH_EN
    grp_cnt_d   = grp_cnt_q;
`endif
    unique case (state_q)
      COLLECT: begin
        if (in_valid && in_ready_q) begin
          for (int k = 0; k < NOPS; k++) begin
            if (idx_q == 3'(k)) ops_d[k] = in_data;
          end
          idx_d = idx_q + 3'd1;
          if (close_grp) begin
            idx_d      = '0;
            in_ready_d = 1'b0;
            state_d    = SUM;
`ifdef OPERAND_COLLECTOR_FLUSH_EN
            grp_cnt_d  = idx_q + 3'd1;
`endif
          end
        end
      end
      SUM: begin
        out_sum_d   = tree_sum;
`ifdef OPERAND_COLLECTOR_FLUSH_EN
        out_count_d = grp_cnt_q;
`else
        out_count_d = 3'(NOPS);
`endif
        state_d     = OUT;
      end
      OUT: begin
        // out_valid rises one cycle after entering OUT; handshake only once it is visible.
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          ops_d       = '0;
          in_ready_d  = 1'b1;
          state_d     = COLLECT;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= COLLECT;
      idx_q       <= '0;
      ops_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
`ifdef OPERAND_COLLECTOR_FLUSH_EN
      grp_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ops_q       <= ops_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
`ifdef OPERAND_COLLECTOR_FLUSH_EN
      grp_cnt_q   <= grp_cnt_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;

endmodule
